// File: rtl/square_select_if.sv
// square_select_if: cursor/button inputs and board/status outputs of the tic-tac-toe square selector
interface square_select_if;
  logic        start_en;
  logic        choice_en;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [8:0]  square;
  logic [8:0]  square_color;
  logic        player;
  logic        place_pulse;
  logic        game_over;
  logic [1:0]  winner;
  modport master (
    output start_en, choice_en, mouse_xpos, mouse_ypos, mouse_left,
    input  square, square_color, player, place_pulse, game_over, winner
  );
  modport slave (
    input  start_en, choice_en, mouse_xpos, mouse_ypos, mouse_left,
    output square, square_color, player, place_pulse, game_over, winner
  );
endinterface

// File: rtl/square_select_ctl.sv
// square_select_ctl: turns mouse clicks on a 3x3 screen grid into tic-tac-toe moves and scores the game
module square_select_ctl (
  input  logic pclk,
  input  logic rst,
  square_select_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;
  localparam logic [7:0][8:0] win_lines = {9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054};
  state_t      state, state_nx;
  logic        prev_left, in_grid, hit, won;
  logic [1:0]  col, row;
  logic [3:0]  idx;
  logic [8:0]  cell_bit, mine, square_nx, color_nx;
  logic        player_nx, pulse_nx, over_nx;
  logic [1:0]  winner_nx;
  always_comb begin
    col = bus.mouse_xpos < 12'd340 ? 2'd0 : bus.mouse_xpos < 12'd685 ? 2'd1 : 2'd2;
    row = bus.mouse_ypos < 12'd252 ? 2'd0 : bus.mouse_ypos < 12'd516 ? 2'd1 : 2'd2;
    in_grid = bus.mouse_xpos < 12'd1024 && bus.mouse_ypos < 12'd768;
    idx = 4'(row) * 4'd3 + 4'(col);
    cell_bit = 9'd1 << idx;
    hit = bus.mouse_left && !prev_left && !bus.choice_en && in_grid && !(|(bus.square & cell_bit));
    // squares owned by the side that just moved
    mine = bus.square & (bus.player ? bus.square_color : ~bus.square_color);
    won = 1'b0;
    for (int i = 0; i < 8; i++) won = won | ((mine & win_lines[i]) == win_lines[i]);
  end
  always_comb begin
    state_nx = state;
    square_nx = bus.square;
    color_nx = bus.square_color;
    player_nx = bus.player;
    pulse_nx = 1'b0;
    over_nx = bus.game_over;
    winner_nx = bus.winner;
    if (!bus.start_en) begin
      state_nx = IDLE;
      square_nx = '0;
      color_nx = '0;
      player_nx = 1'b0;
      over_nx = 1'b0;
      winner_nx = 2'b00;
    end else begin
      case (state)
        IDLE: state_nx = bus.choice_en ? IDLE : PLAY;
        PLAY: if (hit) begin
          square_nx = bus.square | cell_bit;
          color_nx = bus.player ? bus.square_color | cell_bit : bus.square_color & ~cell_bit;
          pulse_nx = 1'b1;
          state_nx = CHECK;
        end
        CHECK: if (won || &bus.square) begin
          winner_nx = won ? (bus.player ? 2'b10 : 2'b01) : 2'b11;
          over_nx = 1'b1;
          state_nx = OVER;
        end else begin
          player_nx = ~bus.player;
          state_nx = PLAY;
        end
        default: state_nx = OVER;
      endcase
    end
  end
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state <= IDLE;
      bus.square <= '0;
      bus.square_color <= '0;
      bus.player <= 1'b0;
      bus.place_pulse <= 1'b0;
      bus.game_over <= 1'b0;
      bus.winner <= 2'b00;
      prev_left <= 1'b0;
    end else begin
      state <= state_nx;
      bus.square <= square_nx;
      bus.square_color <= color_nx;
      bus.player <= player_nx;
      bus.place_pulse <= pulse_nx;
      bus.game_over <= over_nx;
      bus.winner <= winner_nx;
      prev_left <= bus.mouse_left;
    end
  end
endmodule

// File: tb/tb_square_select_ctl.sv
// tb_square_select_ctl: vector table, scripted games and random traffic against a board-level game model
module tb_square_select_ctl;
  logic pclk = 1'b0;
  logic rst = 1'b0;
  always #5 pclk = ~pclk;
  square_select_if bus();
  square_select_ctl dut (.pclk(pclk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int board[9];
  int m_player, m_pulse, m_over, m_winner, m_phase, m_prev;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int bx[6] = '{339, 340, 684, 685, 1023, 1024};
  int by[6] = '{251, 252, 515, 516, 767, 768};
  typedef struct {
    logic rst, start, choice, left;
    int x, y;
    logic [8:0] sq, col;
    logic pl, pu, ov;
    logic [1:0] win;
  } vec_t;
  vec_t tbl[15];
  function automatic int cell_of(int x, int y);
    if (x >= 1024 || y >= 768) return -1;
    return (y < 252 ? 0 : y < 516 ? 1 : 2) * 3 + (x < 340 ? 0 : x < 685 ? 1 : 2);
  endfunction
  task automatic model_clear();
    foreach (board[i]) board[i] = 0;
    m_player = 0; m_pulse = 0; m_over = 0; m_winner = 0; m_phase = 0;
  endtask
  task automatic model_step();
    int c;
    bit click, won, full;
    if (!rst) begin
      model_clear();
      m_prev = 0;
      return;
    end
    click = bus.mouse_left && !m_prev;
    m_prev = bus.mouse_left;
    m_pulse = 0;
    if (!bus.start_en) model_clear();
    else if (m_phase == 0) begin
      if (!bus.choice_en) m_phase = 1;
    end else if (m_phase == 1) begin
      c = cell_of(int'(bus.mouse_xpos), int'(bus.mouse_ypos));
      if (click && !bus.choice_en && c >= 0)
        if (board[c] == 0) begin
          board[c] = m_player + 1;
          m_pulse = 1;
          m_phase = 2;
        end
    end else if (m_phase == 2) begin
      won = 0;
      full = 1;
      foreach (lines[l]) if (board[lines[l][0]] == m_player + 1 && board[lines[l][1]] == m_player + 1 && board[lines[l][2]] == m_player + 1) won = 1;
      foreach (board[i]) if (board[i] == 0) full = 0;
      if (won || full) begin
        m_winner = won ? m_player + 1 : 3;
        m_over = 1;
        m_phase = 3;
      end else begin
        m_player ^= 1;
        m_phase = 1;
      end
    end
  endtask
  function automatic logic [22:0] model_vec();
    logic [8:0] sq, col;
    for (int i = 0; i < 9; i++) begin
      sq[i] = board[i] != 0;
      col[i] = board[i] == 2;
    end
    return {sq, col, 1'(m_player), 1'(m_pulse), 1'(m_over), 2'(m_winner)};
  endfunction
  function automatic logic [22:0] dut_vec();
    return {bus.square, bus.square_color & bus.square, bus.player, bus.place_pulse, bus.game_over, bus.winner};
  endfunction
  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    model_step();
    @(posedge pclk);
    #1;
    check("model", dut_vec(), model_vec());
  endtask
  task automatic aim(input int c);
    bus.mouse_xpos = 12'((c - 1) % 3 == 0 ? 100 : (c - 1) % 3 == 1 ? 500 : 900);
    bus.mouse_ypos = 12'((c - 1) / 3 == 0 ? 100 : (c - 1) / 3 == 1 ? 400 : 700);
  endtask
  task automatic click(input int c);
    aim(c);
    bus.mouse_left = 1'b1;
    step();
    bus.mouse_left = 1'b0;
    step();
    step();
  endtask
  task automatic new_game();
    bus.start_en = 1'b0;
    step();
    check("clear", dut_vec(), 23'd0);
    bus.start_en = 1'b1;
    step();
  endtask
  task automatic play(input int moves[9], input int n);
    new_game();
    for (int i = 0; i < n; i++) click(moves[i]);
  endtask
  initial begin
    int pulses;
    int seq_draw[9] = '{1,2,3,5,4,6,8,7,9};
    int seq_win9[9] = '{1,2,3,5,4,6,8,9,7};
    int seq_row[9]  = '{1,4,2,5,3,0,0,0,0};
    bus.start_en = 1'b0; bus.choice_en = 1'b0; bus.mouse_left = 1'b0;
    bus.mouse_xpos = 12'd0; bus.mouse_ypos = 12'd0;
    model_clear();
    m_prev = 0;
    tbl[0]  = '{0,0,0,0,   0,  0, 9'h000, 9'h000, 0, 0, 0, 2'b00};
    tbl[1]  = '{1,1,0,0,   0,  0, 9'h000, 9'h000, 0, 0, 0, 2'b00};
    tbl[2]  = '{1,1,0,1, 700,100, 9'h004, 9'h000, 0, 1, 0, 2'b00};
    tbl[3]  = '{1,1,0,1, 700,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[4]  = '{1,1,0,1, 700,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[5]  = '{1,1,0,0, 700,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[6]  = '{1,1,0,1, 700,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[7]  = '{1,1,0,0, 700,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[8]  = '{1,1,1,1, 100,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[9]  = '{1,1,0,1, 100,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[10] = '{1,1,0,0, 100,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[11] = '{1,1,0,1,1030,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[12] = '{1,1,0,0, 100,100, 9'h004, 9'h000, 1, 0, 0, 2'b00};
    tbl[13] = '{1,1,0,1, 100,100, 9'h005, 9'h001, 1, 1, 0, 2'b00};
    tbl[14] = '{1,1,0,0, 100,100, 9'h005, 9'h001, 0, 0, 0, 2'b00};
    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.start_en = tbl[i].start; bus.choice_en = tbl[i].choice;
      bus.mouse_left = tbl[i].left;
      bus.mouse_xpos = 12'(tbl[i].x); bus.mouse_ypos = 12'(tbl[i].y);
      step();
      check($sformatf("vec%0d", i), dut_vec(), {tbl[i].sq, tbl[i].col, tbl[i].pl, tbl[i].pu, tbl[i].ov, tbl[i].win});
    end
    play(seq_row, 5);
    check("row_win", dut_vec(), {9'h01F, 9'h018, 1'b0, 1'b0, 1'b1, 2'b01});
    click(6);
    check("after_over", dut_vec(), {9'h01F, 9'h018, 1'b0, 1'b0, 1'b1, 2'b01});
    play(seq_draw, 9);
    check("draw", {bus.square, bus.game_over, bus.winner}, {9'h1FF, 1'b1, 2'b11});
    play(seq_win9, 9);
    check("win9", {bus.square, bus.game_over, bus.winner}, {9'h1FF, 1'b1, 2'b01});
    new_game();
    aim(5);
    bus.mouse_left = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      pulses += int'(bus.place_pulse);
    end
    check("hold_pulses", 23'(pulses), 23'd1);
    bus.mouse_left = 1'b0;
    step();
    click(5);
    check("reclick", {bus.square, bus.player}, {9'h010, 1'b1});
    aim(1);
    bus.mouse_left = 1'b1;
    step();
    check("placed_before_rst", 23'(bus.place_pulse), 23'd1);
    rst = 1'b0;
    bus.mouse_left = 1'b0;
    step();
    check("rst_in_check", dut_vec(), 23'd0);
    rst = 1'b1;
    new_game();
    aim(2);
    bus.mouse_left = 1'b1;
    step();
    bus.start_en = 1'b0;
    bus.mouse_left = 1'b0;
    step();
    check("stop_in_check", dut_vec(), 23'd0);
    bus.start_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst = $urandom_range(499) != 0;
      bus.start_en = $urandom_range(199) != 0;
      bus.choice_en = $urandom_range(9) == 0;
      if ($urandom_range(2) == 0) bus.mouse_left = ~bus.mouse_left;
      if (!bus.mouse_left) begin
        bus.mouse_xpos = 12'($urandom_range(3) == 0 ? bx[$urandom_range(5)] : $urandom_range(1100));
        bus.mouse_ypos = 12'($urandom_range(3) == 0 ? by[$urandom_range(5)] : $urandom_range(820));
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
